// File: rtl/dtlb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dtlb_ctrl_pkg
//  Description : Shared types and constants for the data-TLB miss controller.
//  Revision    : 1.0  initial release
// ============================================================================
package dtlb_ctrl_pkg;

    localparam int c_NPORT = 3;

    // Bit positions inside the 7-bit G,A,D,U,W,R,X permission vector
    localparam int c_GADUWRX_G = 6;
    localparam int c_GADUWRX_A = 5;
    localparam int c_GADUWRX_D = 4;
    localparam int c_GADUWRX_U = 3;
    localparam int c_GADUWRX_W = 2;
    localparam int c_GADUWRX_R = 1;
    localparam int c_GADUWRX_X = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WALK_REQ  = 3'd1,
        ST_WALK_WAIT = 3'd2,
        ST_FILL      = 3'd3,
        ST_FENCE     = 3'd4
    } state_e;

    // Successor of a port index, wrapping 2 -> 0
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb3.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb3
//  Description : 3-way round-robin arbiter. Search starts at the pointer; the
//                pointer moves past the winner whenever a grant is consumed.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb3
    import dtlb_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_req,
    input  logic       i_advance,
    output logic [2:0] o_gnt,
    output logic [1:0] o_gnt_idx,
    output logic       o_valid
);

    logic [1:0] r_ptr;
    logic [1:0] w_cand;

    // Pick the first requester at or after the pointer
    always_comb begin
        o_valid   = 1'b0;
        o_gnt_idx = 2'd0;
        w_cand    = r_ptr;
        for (int i = 0; i < c_NPORT; i++) begin
            if (!o_valid && i_req[w_cand]) begin
                o_valid   = 1'b1;
                o_gnt_idx = w_cand;
            end
            w_cand = next_port(w_cand);
        end
        o_gnt = o_valid ? (3'b001 << o_gnt_idx) : 3'b000;
    end

    // Pointer advances to the port after the one just granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (i_advance && o_valid) begin
            r_ptr <= next_port(o_gnt_idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dtlb_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dtlb_miss_ctrl
//  Description : Data-TLB miss sequencer: arbitrates port misses, issues one
//                page-table walk at a time, fills the TLB, acks requesters
//                (coalescing identical pages) and serialises invalidations.
//  Revision    : 1.0  initial release
// ============================================================================
module dtlb_miss_ctrl
    import dtlb_ctrl_pkg::*;
#(
    parameter int VA_SZ = 48,
    parameter int NPHYS = 44,
    parameter int NPORT = c_NPORT
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [NPORT-1:0]    miss_req,
    input  logic [VA_SZ-13:0]   miss_vaddr_0,
    input  logic [VA_SZ-13:0]   miss_vaddr_1,
    input  logic [VA_SZ-13:0]   miss_vaddr_2,
    input  logic [15:0]         miss_asid_0,
    input  logic [15:0]         miss_asid_1,
    input  logic [15:0]         miss_asid_2,
    output logic [NPORT-1:0]    miss_ack,
    output logic [NPORT-1:0]    miss_fault,
    output logic                ptw_req,
    output logic [VA_SZ-13:0]   ptw_vaddr,
    output logic [15:0]         ptw_asid,
    input  logic                ptw_ack,
    input  logic                ptw_done,
    input  logic                ptw_fault,
    input  logic [NPHYS-13:0]   ptw_paddr,
    input  logic [6:0]          ptw_gaduwrx,
    input  logic                ptw_2mB,
    input  logic                ptw_4mB,
    input  logic                ptw_1gB,
    input  logic                ptw_512gB,
    output logic                wr_entry,
    output logic [VA_SZ-13:0]   wr_vaddr,
    output logic [15:0]         wr_asid,
    output logic [NPHYS-13:0]   wr_paddr,
    output logic [6:0]          wr_gaduwrx,
    output logic                wr_2mB,
    output logic                wr_4mB,
    output logic                wr_1gB,
    output logic                wr_512gB,
    input  logic                fence_req,
    input  logic                fence_asid_valid,
    input  logic [15:0]         fence_asid,
    input  logic                fence_addr_valid,
    input  logic [VA_SZ-13:0]   fence_vaddr,
    input  logic                fence_unified,
    output logic                fence_ack,
    output logic                wr_invalidate,
    output logic                wr_invalidate_asid,
    output logic [15:0]         wr_inv_asid,
    output logic                wr_inv_unified,
    output logic                wr_invalidate_addr,
    output logic [VA_SZ-13:0]   wr_inv_vaddr,
    output logic                busy
);

    state_e             r_state;
    logic [NPORT-1:0]   r_gnt_oh;
    logic [2:0]         w_gnt_oh;
    logic [1:0]         w_gnt_idx;
    logic               w_gnt_valid;
    logic               w_advance;
    logic               w_fill;
    logic [NPORT-1:0]   w_ack_vec;
    logic [NPORT-1:0]   w_fault_vec;
    logic [VA_SZ-13:0]  w_port_vaddr [NPORT];
    logic [15:0]        w_port_asid  [NPORT];

    assign w_port_vaddr[0] = miss_vaddr_0;
    assign w_port_vaddr[1] = miss_vaddr_1;
    assign w_port_vaddr[2] = miss_vaddr_2;
    assign w_port_asid[0]  = miss_asid_0;
    assign w_port_asid[1]  = miss_asid_1;
    assign w_port_asid[2]  = miss_asid_2;

    // A pending fence wins over misses, so the pointer only moves on a real grant
    assign w_advance = (r_state == ST_IDLE) && !fence_req;

    // Walk result arrives: either right after the request or while waiting
    assign w_fill = ((r_state == ST_WALK_REQ) && ptw_ack && ptw_done) ||
                    ((r_state == ST_WALK_WAIT) && ptw_done);

    rr_arb3 u_arb (
        .clk       (clk),
        .rst       (reset),
        .i_req     (miss_req),
        .i_advance (w_advance),
        .o_gnt     (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_valid   (w_gnt_valid)
    );

    // Ack the granted port if still waiting; on success also ack identical pages
    always_comb begin
        w_ack_vec   = '0;
        w_fault_vec = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (r_gnt_oh[p]) begin
                w_ack_vec[p]   = miss_req[p];
                w_fault_vec[p] = miss_req[p] & ptw_fault;
            end else if (!ptw_fault && miss_req[p] &&
                         (w_port_vaddr[p] == ptw_vaddr) &&
                         (w_port_asid[p] == ptw_asid)) begin
                w_ack_vec[p] = 1'b1;
            end
        end
    end

    // Controller FSM; every output is a register updated here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_gnt_oh           <= '0;
            busy               <= 1'b0;
            miss_ack           <= '0;
            miss_fault         <= '0;
            ptw_req            <= 1'b0;
            ptw_vaddr          <= '0;
            ptw_asid           <= '0;
            wr_entry           <= 1'b0;
            wr_vaddr           <= '0;
            wr_asid            <= '0;
            wr_paddr           <= '0;
            wr_gaduwrx         <= '0;
            wr_2mB             <= 1'b0;
            wr_4mB             <= 1'b0;
            wr_1gB             <= 1'b0;
            wr_512gB           <= 1'b0;
            fence_ack          <= 1'b0;
            wr_invalidate      <= 1'b0;
            wr_invalidate_asid <= 1'b0;
            wr_inv_asid        <= '0;
            wr_inv_unified     <= 1'b0;
            wr_invalidate_addr <= 1'b0;
            wr_inv_vaddr       <= '0;
        end else begin
            miss_ack      <= '0;
            miss_fault    <= '0;
            wr_entry      <= 1'b0;
            fence_ack     <= 1'b0;
            wr_invalidate <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (fence_req) begin
                        r_state            <= ST_FENCE;
                        busy               <= 1'b1;
                        wr_invalidate      <= 1'b1;
                        fence_ack          <= 1'b1;
                        wr_invalidate_asid <= fence_asid_valid;
                        wr_inv_asid        <= fence_asid;
                        wr_invalidate_addr <= fence_addr_valid;
                        wr_inv_vaddr       <= fence_vaddr;
                        wr_inv_unified     <= fence_unified;
                    end else if (w_gnt_valid) begin
                        r_state   <= ST_WALK_REQ;
                        busy      <= 1'b1;
                        ptw_req   <= 1'b1;
                        r_gnt_oh  <= w_gnt_oh;
                        ptw_vaddr <= w_port_vaddr[w_gnt_idx];
                        ptw_asid  <= w_port_asid[w_gnt_idx];
                    end
                end
                ST_WALK_REQ: begin
                    if (ptw_ack) begin
                        ptw_req <= 1'b0;
                        r_state <= ptw_done ? ST_FILL : ST_WALK_WAIT;
                    end
                end
                ST_WALK_WAIT: begin
                    if (ptw_done) begin
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                ST_FENCE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    ptw_req <= 1'b0;
                end
            endcase

            // Fill data and acks are captured with the walk result
            if (w_fill) begin
                wr_entry   <= !ptw_fault;
                wr_vaddr   <= ptw_vaddr;
                wr_asid    <= ptw_asid;
                wr_paddr   <= ptw_paddr;
                wr_gaduwrx <= ptw_gaduwrx;
                wr_2mB     <= ptw_2mB;
                wr_4mB     <= ptw_4mB;
                wr_1gB     <= ptw_1gB;
                wr_512gB   <= ptw_512gB;
                miss_ack   <= w_ack_vec;
                miss_fault <= w_fault_vec;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dtlb_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dtlb_miss_ctrl
//  Description : Self-checking bench for dtlb_miss_ctrl: table of single
//                walks plus hand sequences for bursts, fences and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dtlb_miss_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  miss_req;
    logic [35:0] miss_vaddr_0, miss_vaddr_1, miss_vaddr_2;
    logic [15:0] miss_asid_0, miss_asid_1, miss_asid_2;
    logic [2:0]  miss_ack, miss_fault;
    logic        ptw_req;
    logic [35:0] ptw_vaddr;
    logic [15:0] ptw_asid;
    logic        ptw_ack, ptw_done, ptw_fault;
    logic [31:0] ptw_paddr;
    logic [6:0]  ptw_gaduwrx;
    logic        ptw_2mB, ptw_4mB, ptw_1gB, ptw_512gB;
    logic        wr_entry;
    logic [35:0] wr_vaddr;
    logic [15:0] wr_asid;
    logic [31:0] wr_paddr;
    logic [6:0]  wr_gaduwrx;
    logic        wr_2mB, wr_4mB, wr_1gB, wr_512gB;
    logic        fence_req, fence_asid_valid, fence_addr_valid, fence_unified;
    logic [15:0] fence_asid;
    logic [35:0] fence_vaddr;
    logic        fence_ack, wr_invalidate, wr_invalidate_asid, wr_inv_unified;
    logic        wr_invalidate_addr;
    logic [15:0] wr_inv_asid;
    logic [35:0] wr_inv_vaddr;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dtlb_miss_ctrl #(.VA_SZ(48), .NPHYS(44), .NPORT(3)) dut (
        .clk(clk), .reset(reset),
        .miss_req(miss_req),
        .miss_vaddr_0(miss_vaddr_0), .miss_vaddr_1(miss_vaddr_1), .miss_vaddr_2(miss_vaddr_2),
        .miss_asid_0(miss_asid_0), .miss_asid_1(miss_asid_1), .miss_asid_2(miss_asid_2),
        .miss_ack(miss_ack), .miss_fault(miss_fault),
        .ptw_req(ptw_req), .ptw_vaddr(ptw_vaddr), .ptw_asid(ptw_asid),
        .ptw_ack(ptw_ack), .ptw_done(ptw_done), .ptw_fault(ptw_fault),
        .ptw_paddr(ptw_paddr), .ptw_gaduwrx(ptw_gaduwrx),
        .ptw_2mB(ptw_2mB), .ptw_4mB(ptw_4mB), .ptw_1gB(ptw_1gB), .ptw_512gB(ptw_512gB),
        .wr_entry(wr_entry), .wr_vaddr(wr_vaddr), .wr_asid(wr_asid), .wr_paddr(wr_paddr),
        .wr_gaduwrx(wr_gaduwrx), .wr_2mB(wr_2mB), .wr_4mB(wr_4mB), .wr_1gB(wr_1gB),
        .wr_512gB(wr_512gB),
        .fence_req(fence_req), .fence_asid_valid(fence_asid_valid), .fence_asid(fence_asid),
        .fence_addr_valid(fence_addr_valid), .fence_vaddr(fence_vaddr),
        .fence_unified(fence_unified), .fence_ack(fence_ack),
        .wr_invalidate(wr_invalidate), .wr_invalidate_asid(wr_invalidate_asid),
        .wr_inv_asid(wr_inv_asid), .wr_inv_unified(wr_inv_unified),
        .wr_invalidate_addr(wr_invalidate_addr), .wr_inv_vaddr(wr_inv_vaddr),
        .busy(busy)
    );

    typedef struct {
        logic [2:0]  req;
        logic [35:0] va0, va1, va2;
        logic [15:0] as0, as1, as2;
        logic [31:0] pa;
        logic [6:0]  g;
        logic [3:0]  sz;     // {2mB,4mB,1gB,512gB}
        logic        flt;
        int          delay;
        logic [2:0]  drop;
        int          gnt;
        logic [2:0]  exp_ack;
        logic [2:0]  exp_flt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One walk from request to post-fill idle; called right after a negedge
    task automatic do_walk(input string nm, input int exp_lat,
                           input logic [35:0] exp_va, input logic [15:0] exp_as,
                           input logic [31:0] pa, input logic [6:0] g, input logic [3:0] sz,
                           input logic flt, input int delay,
                           input logic [2:0] drop_mask, input logic [2:0] clr_mask,
                           input logic [2:0] exp_ack, input logic [2:0] exp_flt);
        int t;
        t = 0;
        ptw_paddr = pa; ptw_gaduwrx = g; ptw_fault = flt;
        {ptw_2mB, ptw_4mB, ptw_1gB, ptw_512gB} = sz;
        do begin
            @(negedge clk);
            t++;
        end while (!ptw_req && t < 20);
        chk({nm, " ptw_req latency"}, 64'(t), 64'(exp_lat));
        if (!ptw_req) return;
        chk({nm, " ptw_vaddr"}, 64'(ptw_vaddr), 64'(exp_va));
        chk({nm, " ptw_asid"}, 64'(ptw_asid), 64'(exp_as));
        ptw_ack  = 1'b1;
        ptw_done = (delay == 0);
        for (int d = 1; d <= delay; d++) begin
            @(negedge clk);
            if (d == 1) begin
                chk({nm, " ptw_req released"}, 64'(ptw_req), 64'd0);
                miss_req = miss_req & ~drop_mask;
            end
            ptw_ack  = 1'b0;
            ptw_done = (d == delay);
        end
        @(negedge clk);
        ptw_ack = 1'b0; ptw_done = 1'b0;
        chk({nm, " wr_entry"}, 64'(wr_entry), 64'(!flt));
        chk({nm, " miss_ack"}, 64'(miss_ack), 64'(exp_ack));
        chk({nm, " miss_fault"}, 64'(miss_fault), 64'(exp_flt));
        chk({nm, " no inval during fill"}, 64'(wr_invalidate), 64'd0);
        if (!flt) begin
            chk({nm, " wr_vaddr"}, 64'(wr_vaddr), 64'(exp_va));
            chk({nm, " wr_asid"}, 64'(wr_asid), 64'(exp_as));
            chk({nm, " wr_paddr"}, 64'(wr_paddr), 64'(pa));
            chk({nm, " wr_gaduwrx"}, 64'(wr_gaduwrx), 64'(g));
            chk({nm, " wr_size"}, 64'({wr_2mB, wr_4mB, wr_1gB, wr_512gB}), 64'(sz));
        end
        miss_req = miss_req & ~clr_mask;
        @(negedge clk);
        chk({nm, " wr_entry pulse"}, 64'(wr_entry), 64'd0);
        chk({nm, " miss_ack pulse"}, 64'(miss_ack), 64'd0);
        chk({nm, " busy after fill"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [35:0] pick_va(input vec_t v);
        case (v.gnt)
            0:       return v.va0;
            1:       return v.va1;
            default: return v.va2;
        endcase
    endfunction

    function automatic logic [15:0] pick_as(input vec_t v);
        case (v.gnt)
            0:       return v.as0;
            1:       return v.as1;
            default: return v.as2;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_fack;
        int overlap;
        int t;

        // Grant order follows the round-robin pointer, starting at 0 after reset
        //          req     va0           va1           va2           as0      as1      as2      pa            g      sz      flt  dly drop    gnt ack     flt
        vecs[0] = '{3'b010, 36'h0,        36'h12345,    36'h0,        16'd0,   16'd7,   16'd0,   32'h000abcde, 7'h0F, 4'b0000, 1'b0, 5, 3'b000, 1, 3'b010, 3'b000};
        vecs[1] = '{3'b101, 36'h55555,    36'h0,        36'h55555,    16'd3,   16'd0,   16'd3,   32'h00011111, 7'h7F, 4'b1000, 1'b0, 2, 3'b000, 2, 3'b101, 3'b000};
        vecs[2] = '{3'b011, 36'h777,      36'h777,      36'h0,        16'd9,   16'd9,   16'd0,   32'h00022222, 7'h01, 4'b0000, 1'b1, 1, 3'b000, 0, 3'b001, 3'b001};
        vecs[3] = '{3'b100, 36'h0,        36'h0,        36'hFFFFFFFFF,16'd0,   16'd0,   16'hFFFF,32'hFFFFFFFF, 7'h55, 4'b0001, 1'b0, 0, 3'b000, 2, 3'b100, 3'b000};
        vecs[4] = '{3'b011, 36'h100,      36'h101,      36'h0,        16'd1,   16'd1,   16'd0,   32'h00033333, 7'h2A, 4'b0100, 1'b0, 3, 3'b000, 0, 3'b001, 3'b000};
        vecs[5] = '{3'b110, 36'h0,        36'h200,      36'h200,      16'd0,   16'd1,   16'd2,   32'h00044444, 7'h03, 4'b0010, 1'b0, 1, 3'b000, 1, 3'b010, 3'b000};
        vecs[6] = '{3'b100, 36'h0,        36'h0,        36'h3,        16'd0,   16'd0,   16'd4,   32'h00055555, 7'h41, 4'b0000, 1'b0, 2, 3'b100, 2, 3'b000, 3'b000};

        reset = 1'b1;
        miss_req = '0;
        miss_vaddr_0 = '0; miss_vaddr_1 = '0; miss_vaddr_2 = '0;
        miss_asid_0 = '0; miss_asid_1 = '0; miss_asid_2 = '0;
        ptw_ack = 0; ptw_done = 0; ptw_fault = 0; ptw_paddr = '0; ptw_gaduwrx = '0;
        ptw_2mB = 0; ptw_4mB = 0; ptw_1gB = 0; ptw_512gB = 0;
        fence_req = 0; fence_asid_valid = 0; fence_asid = '0; fence_addr_valid = 0;
        fence_vaddr = '0; fence_unified = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset ptw_req", 64'(ptw_req), 64'd0);
        chk("reset strobes", 64'({wr_entry, wr_invalidate, fence_ack, miss_ack, miss_fault}), 64'd0);
        chk("reset data", 64'(ptw_vaddr | wr_vaddr | wr_inv_vaddr), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- table of single walks ----------------
        for (int i = 0; i < 7; i++) begin
            miss_vaddr_0 = vecs[i].va0; miss_vaddr_1 = vecs[i].va1; miss_vaddr_2 = vecs[i].va2;
            miss_asid_0  = vecs[i].as0; miss_asid_1  = vecs[i].as1; miss_asid_2  = vecs[i].as2;
            miss_req     = vecs[i].req;
            do_walk($sformatf("vec%0d", i), 1, pick_va(vecs[i]), pick_as(vecs[i]),
                    vecs[i].pa, vecs[i].g, vecs[i].sz, vecs[i].flt, vecs[i].delay,
                    vecs[i].drop, 3'b111, vecs[i].exp_ack, vecs[i].exp_flt);
        end

        // ---------------- two bursts on all ports: order 0,1,2 each time ----------------
        for (int b = 0; b < 2; b++) begin
            miss_vaddr_0 = 36'hA00 + 36'(b * 16); miss_asid_0 = 16'd10;
            miss_vaddr_1 = 36'hA01 + 36'(b * 16); miss_asid_1 = 16'd11;
            miss_vaddr_2 = 36'hA02 + 36'(b * 16); miss_asid_2 = 16'd12;
            miss_req = 3'b111;
            do_walk($sformatf("burst%0d p0", b), 1, 36'hA00 + 36'(b * 16), 16'd10,
                    32'h100, 7'h0F, 4'b0000, 1'b0, 1, 3'b000, 3'b001, 3'b001, 3'b000);
            do_walk($sformatf("burst%0d p1", b), 1, 36'hA01 + 36'(b * 16), 16'd11,
                    32'h101, 7'h0F, 4'b0000, 1'b0, 1, 3'b000, 3'b010, 3'b010, 3'b000);
            do_walk($sformatf("burst%0d p2", b), 1, 36'hA02 + 36'(b * 16), 16'd12,
                    32'h102, 7'h0F, 4'b0000, 1'b0, 1, 3'b000, 3'b100, 3'b100, 3'b000);
        end

        // ---------------- fence arriving during WALK_WAIT ----------------
        miss_vaddr_0 = 36'h4242; miss_asid_0 = 16'h11;
        ptw_fault = 0; ptw_paddr = 32'h4242; ptw_gaduwrx = 7'h0F;
        miss_req = 3'b001;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ptw_req && t < 20);
        chk("fwalk ptw_req seen", 64'(ptw_req), 64'd1);
        ptw_ack = 1'b1;
        @(negedge clk);
        ptw_ack = 1'b0;
        fence_req = 1; fence_asid_valid = 1; fence_asid = 16'd5;
        fence_addr_valid = 1; fence_vaddr = 36'h9999; fence_unified = 0;
        @(negedge clk);
        chk("fwalk fence held off", 64'({wr_invalidate, fence_ack}), 64'd0);
        chk("fwalk busy", 64'(busy), 64'd1);
        @(negedge clk);
        ptw_done = 1'b1;
        @(negedge clk);
        ptw_done = 1'b0;
        chk("fwalk fill", 64'(wr_entry), 64'd1);
        chk("fwalk fill ack", 64'(miss_ack), 64'b001);
        chk("fwalk fill not inval", 64'({wr_invalidate, fence_ack}), 64'd0);
        miss_req = 3'b000;
        n_fack = 0; overlap = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wr_entry && wr_invalidate) overlap++;
            if (fence_ack) begin
                n_fack++;
                chk("fwalk wr_invalidate", 64'(wr_invalidate), 64'd1);
                chk("fwalk inv_asid", 64'({wr_invalidate_asid, wr_inv_asid}), 64'h10005);
                chk("fwalk inv_addr", 64'({wr_invalidate_addr, wr_inv_vaddr}), 64'h1000009999);
                chk("fwalk inv_unified", 64'(wr_inv_unified), 64'd0);
                fence_req = 1'b0;
            end
        end
        chk("fwalk fence_ack count", 64'(n_fack), 64'd1);
        chk("fwalk fill/inval overlap", 64'(overlap), 64'd0);
        chk("fwalk idle", 64'(busy), 64'd0);

        // ---------------- fence and miss together in IDLE: fence first ----------------
        miss_vaddr_1 = 36'h777777; miss_asid_1 = 16'h22;
        fence_req = 1; fence_asid_valid = 0; fence_addr_valid = 0; fence_unified = 1;
        miss_req = 3'b010;
        @(negedge clk);
        chk("fmiss fence first", 64'({fence_ack, wr_invalidate, ptw_req}), 64'b110);
        chk("fmiss unified", 64'(wr_inv_unified), 64'd1);
        fence_req = 1'b0;
        do_walk("fmiss walk", 2, 36'h777777, 16'h22, 32'h7, 7'h07, 4'b0000, 1'b0, 1,
                3'b000, 3'b111, 3'b010, 3'b000);

        // ---------------- reset in WALK_WAIT; stale ptw_done ignored ----------------
        miss_vaddr_2 = 36'h31337; miss_asid_2 = 16'h33;
        miss_req = 3'b100;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!ptw_req && t < 20);
        chk("rst ptw_req seen", 64'(ptw_req), 64'd1);
        ptw_ack = 1'b1;
        @(negedge clk);
        ptw_ack = 1'b0;
        chk("rst walk busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst async ptw_req", 64'(ptw_req), 64'd0);
        chk("rst async busy", 64'(busy), 64'd0);
        chk("rst async ptw_vaddr", 64'(ptw_vaddr), 64'd0);
        miss_req = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ptw_done = 1'b1;
        @(negedge clk);
        ptw_done = 1'b0;
        chk("stale done wr_entry", 64'(wr_entry), 64'd0);
        chk("stale done ack", 64'(miss_ack), 64'd0);
        chk("stale done busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
